// File: rtl/col_buff_writer_if.sv
// Handshake bundle for the column-buffer writer. It carries the pixel source stream,
// the FIFO flags and read strobe, and the writer's FIFO write port and status.
interface col_buff_writer_if #(
   parameter int W_ADDR = 8,
   parameter int W_DATA = 8
);
   logic              i_enable;
   logic              i_pix_valid;
   logic [W_DATA-1:0] i_pix_data;
   logic              o_pix_ready;
   logic              i_fifo_full;
   logic              i_fifo_empty;
   logic              i_read_enable;
   logic              o_write_enable;
   logic [W_DATA-1:0] o_write_data;
   logic [W_ADDR:0]   o_occupants;
   logic              o_frame_done;
   logic              o_busy;

   modport master (
      input  i_enable, i_pix_valid, i_pix_data, i_fifo_full, i_fifo_empty, i_read_enable,
      output o_pix_ready, o_write_enable, o_write_data, o_occupants, o_frame_done, o_busy
   );

   modport slave (
      output i_enable, i_pix_valid, i_pix_data, i_fifo_full, i_fifo_empty, i_read_enable,
      input  o_pix_ready, o_write_enable, o_write_data, o_occupants, o_frame_done, o_busy
   );
endinterface

// File: rtl/col_buff_writer.sv
// Column-buffer writer: streams one frame of ROW*COL pixels plus a zero terminator
// into a FIFO, and tracks how many words the FIFO holds for the reader controller.
module col_buff_writer #(
   parameter int COL    = 3,
   parameter int ROW    = 9,
   parameter int W_ADDR = 8,
   parameter int W_DATA = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   col_buff_writer_if.master bus
);
   localparam int              N       = ROW * COL;
   localparam int              W_CNT   = $clog2(N + 1);
   localparam logic [W_ADDR:0] DEPTH_V = {1'b1, {W_ADDR{1'b0}}};

   typedef enum logic [1:0] {IDLE, FILL, TERM, DRAIN} state_t;

   state_t            state_q;
   logic [W_CNT-1:0]  cnt_q;
   logic [W_ADDR:0]   occ_q, occ_d;
   logic              we_q;
   logic [W_DATA-1:0] wdata_q;
   logic              done_q;
   logic              busy_q;

   logic space_ok, accept, term_issue, drain_done;

   // A read strobe on an empty count is dropped so the count can never wrap.
   function automatic logic [W_ADDR:0] occ_update(input logic [W_ADDR:0] occ,
                                                  input logic            inc,
                                                  input logic            dec_req);
      logic dec;
      dec = dec_req && (occ != '0);
      case ({inc, dec})
         2'b10:   return occ + 1'b1;
         2'b01:   return occ - 1'b1;
         default: return occ;
      endcase
   endfunction

   always_comb begin
      space_ok   = !bus.i_fifo_full && (occ_q < DEPTH_V);
      accept     = (state_q == FILL) && space_ok && bus.i_pix_valid;
      term_issue = (state_q == TERM) && space_ok;
      drain_done = (state_q == DRAIN) && (occ_q == '0) && bus.i_fifo_empty;
      occ_d      = occ_update(occ_q, accept || term_issue, bus.i_read_enable);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         occ_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         we_q   <= accept || term_issue;
         done_q <= drain_done;
         if (accept)
            wdata_q <= bus.i_pix_data;
         else if (term_issue)
            wdata_q <= '0;

         case (state_q)
            IDLE: begin
               if (bus.i_enable) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            FILL: begin
               if (accept) begin
                  cnt_q <= cnt_q + W_CNT'(1);
                  if (cnt_q == W_CNT'(N - 1))
                     state_q <= TERM;
               end
            end
            TERM: begin
               if (term_issue)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               // The frame is only retired once both our count and the FIFO agree it is empty.
               if (drain_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_pix_ready    = (state_q == FILL) && space_ok;
   assign bus.o_write_enable = we_q;
   assign bus.o_write_data   = wdata_q;
   assign bus.o_occupants    = occ_q;
   assign bus.o_frame_done   = done_q;
   assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_col_buff_writer.sv
// Bench for col_buff_writer: directed frames plus randomized frames, checked every cycle
// against a counter-based model of one frame (pixels taken, terminator sent, FIFO fill).
module tb_col_buff_writer;
   localparam int COL    = 3;
   localparam int ROW    = 9;
   localparam int W_ADDR = 8;
   localparam int W_DATA = 8;
   localparam int N      = COL * ROW;
   localparam int DEPTH  = 1 << W_ADDR;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   col_buff_writer_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

   col_buff_writer #(.COL(COL), .ROW(ROW), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the frame in progress
   bit                m_active;
   bit                m_term;
   int                m_cnt;
   int                m_occ;
   logic [W_DATA-1:0] m_data;
   logic [W_DATA-1:0] wq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_term   = 1'b0;
      m_cnt    = 0;
      m_occ    = 0;
      m_data   = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_we"},    bus.o_write_enable, 0);
      check({tag, "_wdata"}, bus.o_write_data,   0);
      check({tag, "_occ"},   bus.o_occupants,    0);
      check({tag, "_done"},  bus.o_frame_done,   0);
      check({tag, "_busy"},  bus.o_busy,         0);
      check({tag, "_ready"}, bus.o_pix_ready,    0);
   endtask

   // One clock: check ready against the model, advance the model, then check registered outputs.
   task automatic tick();
      logic exp_rdy, acc, term, done, dec, exp_we;
      logic [W_DATA-1:0] pix;
      #1;
      exp_rdy = m_active && (m_cnt < N) && !bus.i_fifo_full && (m_occ < DEPTH);
      check("pix_ready", {31'd0, bus.o_pix_ready}, {31'd0, exp_rdy});
      acc    = exp_rdy && bus.i_pix_valid;
      term   = m_active && (m_cnt == N) && !m_term && !bus.i_fifo_full && (m_occ < DEPTH);
      done   = m_active && m_term && (m_occ == 0) && bus.i_fifo_empty;
      dec    = bus.i_read_enable && (m_occ > 0);
      pix    = bus.i_pix_data;
      exp_we = acc || term;
      if (acc) begin
         m_cnt++;
         m_data = pix;
      end else if (term) begin
         m_term = 1'b1;
         m_data = '0;
      end
      m_occ = m_occ + (exp_we ? 1 : 0) - (dec ? 1 : 0);
      if (done)
         m_active = 1'b0;
      else if (!m_active && bus.i_enable) begin
         m_active = 1'b1;
         m_cnt    = 0;
         m_term   = 1'b0;
      end
      @(posedge clk);
      #1;
      check("write_enable", {31'd0, bus.o_write_enable}, {31'd0, exp_we});
      check("write_data",   {24'd0, bus.o_write_data},   {24'd0, m_data});
      check("occupants",    {23'd0, bus.o_occupants},    m_occ);
      check("frame_done",   {31'd0, bus.o_frame_done},   {31'd0, done});
      check("busy",         {31'd0, bus.o_busy},         {31'd0, m_active});
      if (bus.o_write_enable) wq.push_back(bus.o_write_data);
   endtask

   task automatic check_words(input string tag, input bit seq);
      check({tag, "_nwords"}, wq.size(), N + 1);
      if (wq.size() == N + 1) begin
         check({tag, "_terminator"}, {24'd0, wq[N]}, 0);
         if (seq)
            for (int i = 0; i < N; i++)
               check({tag, "_pix"}, {24'd0, wq[i]}, i + 1);
      end
   endtask

   task automatic run_frame(input bit rnd, input string tag);
      wq.delete();
      bus.i_enable      = 1'b1;
      bus.i_fifo_full   = 1'b0;
      bus.i_read_enable = 1'b0;
      bus.i_fifo_empty  = (m_occ == 0);
      tick();
      bus.i_enable = 1'b0;
      for (int k = 0; k < 3000 && m_active; k++) begin
         bus.i_pix_valid   = rnd ? ($urandom_range(3) != 0) : 1'b1;
         bus.i_pix_data    = rnd ? W_DATA'($urandom) : W_DATA'(m_cnt + 1);
         bus.i_fifo_full   = rnd ? ($urandom_range(4) == 0) : 1'b0;
         bus.i_read_enable = rnd ? ($urandom_range(2) == 0) : (m_term && m_occ > 0);
         bus.i_fifo_empty  = (m_occ == 0);
         tick();
      end
      check({tag, "_finished"}, {31'd0, bus.o_busy}, 0);
      check_words(tag, !rnd);
   endtask

   initial begin
      bit sim_done, bp_done;
      rst_n             = 1'b1;
      bus.i_enable      = 1'b0;
      bus.i_pix_valid   = 1'b0;
      bus.i_pix_data    = '0;
      bus.i_fifo_full   = 1'b0;
      bus.i_fifo_empty  = 1'b0;
      bus.i_read_enable = 1'b0;
      model_reset();

      // Reset takes effect before any clock edge
      #1 rst_n = 1'b0;
      #1 check_zero("rst_init");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Frame A: constant valid, data 1..27, no reads; enable dropped right after start
      wq.delete();
      bus.i_enable    = 1'b1;
      bus.i_pix_valid = 1'b1;
      tick();
      bus.i_enable = 1'b0;
      for (int k = 0; k < 100 && !m_term; k++) begin
         bus.i_pix_data = W_DATA'(m_cnt + 1);
         tick();
      end
      tick();
      check("A_occ",   {23'd0, bus.o_occupants}, 28);
      check("A_busy",  {31'd0, bus.o_busy}, 1);
      check("A_ready", {31'd0, bus.o_pix_ready}, 0);
      check_words("A", 1'b1);

      // Drain: 28 reads, then the FIFO reports empty
      bus.i_read_enable = 1'b1;
      repeat (28) tick();
      bus.i_read_enable = 1'b0;
      check("D_occ0",  {23'd0, bus.o_occupants}, 0);
      check("D_busy1", {31'd0, bus.o_busy}, 1);
      bus.i_fifo_empty = 1'b1;
      tick();
      check("D_done",  {31'd0, bus.o_frame_done}, 1);
      check("D_busy0", {31'd0, bus.o_busy}, 0);
      tick();
      check("D_done_once", {31'd0, bus.o_frame_done}, 0);
      bus.i_read_enable = 1'b1;
      tick();
      check("D_occ_nowrap", {23'd0, bus.o_occupants}, 0);
      bus.i_read_enable = 1'b0;
      repeat (2) tick();
      check("D_no_restart", {31'd0, bus.o_busy}, 0);

      // Frame B: read on an accept cycle at 5 words, FIFO full for 3 cycles after the 10th accept
      wq.delete();
      bus.i_fifo_empty = 1'b0;
      bus.i_enable     = 1'b1;
      tick();
      bus.i_enable = 1'b0;
      sim_done = 1'b0;
      bp_done  = 1'b0;
      for (int k = 0; k < 200 && !m_term; k++) begin
         bus.i_pix_data = W_DATA'(m_cnt + 1);
         if (m_cnt == 5 && !sim_done) begin
            check("B_occ_before", {23'd0, bus.o_occupants}, 5);
            bus.i_read_enable = 1'b1;
            tick();
            bus.i_read_enable = 1'b0;
            sim_done = 1'b1;
            check("B_occ_simul", {23'd0, bus.o_occupants}, 5);
            check("B_we_simul",  {31'd0, bus.o_write_enable}, 1);
         end else if (m_cnt == 10 && !bp_done) begin
            bus.i_fifo_full = 1'b1;
            repeat (3) begin
               tick();
               check("B_bp_ready", {31'd0, bus.o_pix_ready}, 0);
               check("B_bp_we",    {31'd0, bus.o_write_enable}, 0);
            end
            bus.i_fifo_full = 1'b0;
            bp_done = 1'b1;
         end else begin
            tick();
         end
      end
      for (int k = 0; k < 200 && m_active; k++) begin
         bus.i_read_enable = (m_occ > 0);
         bus.i_fifo_empty  = (m_occ == 0);
         tick();
      end
      bus.i_read_enable = 1'b0;
      check("B_finished", {31'd0, bus.o_busy}, 0);
      check_words("B", 1'b1);

      // Frame C: reset asserted mid-FILL after 5 accepts
      bus.i_fifo_empty = 1'b0;
      bus.i_enable     = 1'b1;
      tick();
      bus.i_enable = 1'b0;
      for (int k = 0; k < 50 && m_cnt < 5; k++) begin
         bus.i_pix_data = W_DATA'(m_cnt + 1);
         tick();
      end
      check("C_occ_before", {23'd0, bus.o_occupants}, 5);
      rst_n = 1'b0;
      #1 check_zero("C_rst");
      model_reset();
      wq.delete();
      @(negedge clk) rst_n = 1'b1;
      bus.i_fifo_empty = 1'b1;
      repeat (2) tick();
      check("C_needs_enable", {31'd0, bus.o_busy}, 0);
      run_frame(1'b0, "C");

      // Randomized frames
      for (int f = 0; f < 4; f++) run_frame(1'b1, "R");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
